// File: rtl/alu_divider_seq.sv
// alu_divider_seq: multi-cycle non-restoring divider for the ALU.
// One quotient bit is produced per clock. Signed operation divides the
// operand magnitudes and then corrects the signs. A zero divisor skips
// the iteration and reports all-ones quotient with the dividend as remainder.
// Results are registered on entry to DONE and held until the next result
// or a reset.
module alu_divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FIXUP  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a value whose sign has already been decided. The
    // magnitude of MIN_INT is the unsigned value 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? twos_neg(v) : v;
    endfunction

    state_t           state_r;
    state_t           state_nx_s;

    // Partial remainder A is WIDTH+1 bits wide. It carries a sign bit and
    // wraps modulo 2**(WIDTH+1) in intermediate steps. The final value lies
    // in [-M, M), so it is always representable.
    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH:0]   m_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             div_zero_s;
    logic [WIDTH:0]   a_sh_s;
    logic [WIDTH:0]   a_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [WIDTH-1:0] rem_mag_s;
    logic [WIDTH-1:0] q_res_s;
    logic [WIDTH-1:0] r_res_s;

    assign div_zero_s = (divisor == {WIDTH{1'b0}});

    // Next-state logic of the divide sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (div_zero_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_DIVIDE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_FIXUP;
                end else begin
                    state_nx_s = ST_DIVIDE;
                end
            end
            ST_FIXUP: state_nx_s = ST_DONE;
            ST_DONE:  state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // One non-restoring step. The add/subtract decision uses the sign of A
    // before the shift. The new quotient bit is set when the result is
    // non-negative.
    always_comb begin
        a_sh_s   = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
        a_step_s = {(WIDTH+1){1'b0}};
        if (a_r[WIDTH]) begin
            a_step_s = a_sh_s + m_r;
        end else begin
            a_step_s = a_sh_s - m_r;
        end
        q_step_s = {q_r[WIDTH-2:0], ~a_step_s[WIDTH]};
    end

    // Final remainder correction and sign fix-up of both results. The
    // corrected remainder is in [0, M), so WIDTH bits are enough.
    always_comb begin
        rem_mag_s = a_r[WIDTH-1:0];
        if (a_r[WIDTH]) begin
            rem_mag_s = a_r[WIDTH-1:0] + m_r[WIDTH-1:0];
        end else begin
            rem_mag_s = a_r[WIDTH-1:0];
        end
        q_res_s = neg_q_r ? twos_neg(q_r) : q_r;
        r_res_s = neg_r_r ? twos_neg(rem_mag_s) : rem_mag_s;
    end

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == ST_DIVIDE) || (state_nx_s == ST_FIXUP);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= {(WIDTH+1){1'b0}};
            q_r         <= {WIDTH{1'b0}};
            m_r         <= {(WIDTH+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && div_zero_s) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= dividend;
                        dbz_r       <= 1'b1;
                    end else if (start) begin
                        a_r     <= {(WIDTH+1){1'b0}};
                        q_r     <= magnitude(dividend, signed_mode & dividend[WIDTH-1]);
                        m_r     <= {1'b0, magnitude(divisor, signed_mode & divisor[WIDTH-1])};
                        cnt_r   <= CNT_INIT;
                        neg_q_r <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_r <= signed_mode & dividend[WIDTH-1];
                    end
                end
                ST_DIVIDE: begin
                    a_r   <= a_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r - CNT_LAST;
                end
                ST_FIXUP: begin
                    quotient_r  <= q_res_s;
                    remainder_r <= r_res_s;
                    dbz_r       <= 1'b0;
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Self-checking bench for alu_divider_seq (WIDTH=32): directed table,
// handshake corner sequences and a random sweep against an arithmetic model.
module tb_alu_divider_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = 32'd0;
    logic [W-1:0] divisor = 32'd0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_divider_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sm;
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
    } vec_t;

    vec_t tbl[17];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic. '/' truncates toward zero and
    // '%' takes the dividend's sign.
    function automatic void ref_div(input logic sm, input logic [W-1:0] dd, input logic [W-1:0] dv,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint a, b, qq, rr;
        if (dv == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = dd;
            z = 1'b1;
            return;
        end
        if (sm) begin
            a = longint'($signed(dd));
            b = longint'($signed(dv));
        end else begin
            a = longint'({32'd0, dd});
            b = longint'({32'd0, dv});
        end
        qq = a / b;
        rr = a % b;
        q = qq[31:0];
        r = rr[31:0];
        z = 1'b0;
    endfunction

    // Called at the negedge of cycle 1 after the accepting edge. Waits up to
    // 60 cycles for done. Every cycle before done must show busy.
    task automatic wait_done(output int lat, output int busy_bad, output logic [W-1:0] q,
                             output logic [W-1:0] r, output logic z, output logic busy_at_done);
        lat = 0;
        busy_bad = 0;
        q = 32'd0;
        r = 32'd0;
        z = 1'b0;
        busy_at_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                q = quotient;
                r = remainder;
                z = div_by_zero;
                busy_at_done = busy;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
            @(negedge clk);
        end
    endtask

    // Issue one operation, then scramble the operand inputs after the
    // accepting edge and check the result and handshake timing.
    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] dd, input logic [W-1:0] dv,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int lat, bb;
        logic [W-1:0] q, r;
        logic z, bd;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        start = 1'b1;
        signed_mode = sm;
        dividend = dd;
        divisor = dv;
        @(negedge clk);
        start = 1'b0;
        signed_mode = ~sm;
        dividend = $urandom;
        divisor = $urandom;
        wait_done(lat, bb, q, r, z, bd);
        chk({tag, "_latency"}, lat, (dv == 32'd0) ? 32'd1 : 32'd34);
        chk({tag, "_busy"}, {bb[30:0], bd}, 32'd0);
        chk({tag, "_quotient"}, q, eq);
        chk({tag, "_remainder"}, r, er);
        chk({tag, "_dbz"}, z, ez);
    endtask

    initial begin : main
        int lat, bb, seen;
        logic [W-1:0] q, r, eq, er, dd, dv;
        logic z, ez, bd, sm;
        int sel;

        tbl[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        tbl[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        tbl[3]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        tbl[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0};
        tbl[5]  = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0};
        tbl[6]  = '{1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
        tbl[7]  = '{1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        tbl[8]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[9]  = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
        tbl[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        tbl[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        tbl[12] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        tbl[13] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        tbl[14] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        tbl[15] = '{1'b1, 32'd7,          32'h8000_0000,  32'd0,          32'd7,          1'b0};
        tbl[16] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].sm, tbl[i].dd, tbl[i].dv, tbl[i].eq, tbl[i].er, tbl[i].ez);
        end

        // Start held high, operands changed while busy: only the first
        // operation runs. Start seen in DONE is ignored; the operation is
        // accepted on the following IDLE cycle.
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        @(negedge clk);
        signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        wait_done(lat, bb, q, r, z, bd);
        chk("hold_latency", lat, 32'd34);
        chk("hold_busy", {bb[30:0], bd}, 32'd0);
        chk("hold_quotient", q, 32'hFFFF_FFF2);
        chk("hold_remainder", r, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("b2b_idle_busy", busy, 1'b0);
        chk("b2b_idle_done", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bb, q, r, z, bd);
        chk("b2b_latency", lat, 32'd34);
        chk("b2b_quotient", q, 32'd100);
        chk("b2b_remainder", r, 32'd0);
        chk("b2b_dbz", z, 1'b0);

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_dbz", div_by_zero, 1'b0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_report", seen, 32'd0);
        chk("abort_hold_quotient", quotient, 32'd0);

        // Random sweep against the reference model
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom_range(0, 1));
            dd = $urandom;
            dv = $urandom;
            sel = $urandom_range(0, 15);
            case (sel)
                0: dv = 32'd0;
                1: dv = 32'd1;
                2: dv = 32'hFFFF_FFFF;
                3: dd = 32'h8000_0000;
                4, 5, 6, 7: dv = dv >> $urandom_range(1, 31);
                8: dd = dd >> $urandom_range(0, 31);
                default: ;
            endcase
            ref_div(sm, dd, dv, eq, er, ez);
            run_op($sformatf("rnd%0d", i), sm, dd, dv, eq, er, ez);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
